// File: rtl/pipe_pkg.sv
// Shared types and default widths for the decode/execute pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 111;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-low clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// Decode->execute pipeline register with a one-entry skid buffer,
// flush, and stall/flush statistics.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_t            state_q;
    logic              main_vld_q, skid_vld_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q     <= ST_EMPTY;
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_q     <= ST_FULL;
                        main_vld_q  <= 1'b1;
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end
                end
                ST_FULL: begin
                    if (in_valid && out_ready) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end else if (in_valid) begin
                        state_q     <= ST_SKID;
                        skid_vld_q  <= 1'b1;
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                    end else if (out_ready) begin
                        // Drained: zero payload so the bubble reads as a no-op
                        state_q     <= ST_EMPTY;
                        main_vld_q  <= 1'b0;
                        main_ctrl_q <= '0;
                        main_data_q <= '0;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        state_q     <= ST_FULL;
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                        skid_vld_q  <= 1'b0;
                        skid_ctrl_q <= '0;
                        skid_data_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = !skid_vld_q;
    assign out_valid = main_vld_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (main_vld_q && !out_ready),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (flush),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed + randomized bench for pipe_reg_skid against a queue-based model.
module tb_pipe_reg_skid;

    localparam int DW  = 111;
    localparam int CW  = 8;
    localparam int NW  = 4;
    localparam int MAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_reg_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    // Model: an in-order FIFO of at most two entries plus two counters
    logic [CW+DW-1:0] mq[$];
    int  m_stall = 0;
    int  m_flush = 0;
    bit  started = 0;

    always @(posedge clk) begin
        bit pop, push;
        if (!rst_n) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
            started = 1;
        end else begin
            if (mq.size() > 0 && !out_ready && m_stall < MAX) m_stall++;
            if (flush) begin
                mq.delete();
                if (m_flush < MAX) m_flush++;
            end else begin
                pop  = (mq.size() > 0) && out_ready;
                push = in_valid && (mq.size() < 2);
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back({in_ctrl, in_data});
            end
        end
    end

    always @(negedge clk) begin
        logic [CW+DW-1:0] e;
        logic             ev, er;
        if (started) begin
            e  = (mq.size() > 0) ? mq[0] : '0;
            ev = mq.size() > 0;
            er = mq.size() < 2;
            n_tests++;
            if (out_valid !== ev || in_ready !== er ||
                {out_ctrl, out_data} !== e ||
                int'(stall_cnt) != m_stall || int'(flush_cnt) != m_flush) begin
                n_fail++;
                $display("FAIL model t=%0t got v=%b r=%b c=%h d=%h s=%0d f=%0d want v=%b r=%b c=%h d=%h s=%0d f=%0d",
                         $time, out_valid, in_ready, out_ctrl, out_data,
                         stall_cnt, flush_cnt, ev, er, e[CW+DW-1:DW],
                         e[DW-1:0], m_stall, m_flush);
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] r;

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_ctrl", 128'(out_ctrl), 128'd0);
        check("rst_out_data", 128'(out_data), 128'd0);
        check("rst_cnts", 128'({stall_cnt, flush_cnt}), 128'd0);

        out_ready = 1'b1;
        push(8'h1F, 111'h5);
        check("basic_valid", 128'(out_valid), 128'd1);
        check("basic_ctrl", 128'(out_ctrl), 128'h1F);
        check("basic_data", 128'(out_data), 128'h5);
        tick();
        check("basic_empty", 128'({out_valid, in_ready, out_ctrl}), 128'h100);

        out_ready = 1'b0;
        push(8'h01, 111'h11);
        push(8'h02, 111'h22);
        check("skid_in_ready", 128'(in_ready), 128'd0);
        check("skid_head", 128'(out_data), 128'h11);
        tick();
        check("skid_stall2", 128'(stall_cnt), 128'd2);
        out_ready = 1'b1;
        tick();
        check("skid_second", 128'(out_data), 128'h22);
        check("skid_ctrl2", 128'(out_ctrl), 128'h02);
        tick();
        check("skid_drained", 128'(out_valid), 128'd0);
        check("skid_stall_kept", 128'(stall_cnt), 128'd2);

        out_ready = 1'b0;
        push(8'h03, 111'h33);
        push(8'h04, 111'h44);
        in_valid = 1'b1;
        in_ctrl  = 8'h05;
        in_data  = 111'h55;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_outs", 128'({out_valid, in_ready, out_ctrl}), 128'h100);
        check("flush_cnt", 128'(flush_cnt), 128'd1);
        check("flush_stall", 128'(stall_cnt), 128'd4);
        out_ready = 1'b1;
        tick();
        check("flush_no_ghost", 128'(out_valid), 128'd0);

        out_ready = 1'b0;
        push(8'h06, 111'h66);
        push(8'h07, 111'h77);
        rst_n = 1'b0;
        flush = 1'b1;
        tick();
        rst_n = 1'b1;
        flush = 1'b0;
        check("rstflush_outs",
              128'({out_valid, in_ready, out_ctrl, out_data[7:0]}), 128'h10000);
        check("rstflush_cnts", 128'({stall_cnt, flush_cnt}), 128'd0);

        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = DW'(i);
            in_ctrl = CW'(i);
            tick();
            if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
                n_fail++;
                $display("FAIL stream[%0d] got v=%b d=%0d want v=1 d=%0d",
                         i, out_valid, out_data, i);
            end
            n_tests++;
        end
        in_valid = 1'b0;
        tick();
        check("stream_stall0", 128'(stall_cnt), 128'd0);

        out_ready = 1'b0;
        push(8'h08, 111'h88);
        repeat (20) tick();
        check("stall_sat", 128'(stall_cnt), 128'd15);
        flush = 1'b1;
        repeat (20) tick();
        flush = 1'b0;
        check("flush_sat", 128'(flush_cnt), 128'd15);
        check("flush_sat_empty", 128'(out_valid), 128'd0);

        for (int i = 0; i < 3000; i++) begin
            r         = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 99) < 4);
            rst_n     = ($urandom_range(0, 199) != 0);
            in_ctrl   = CW'($urandom);
            in_data   = r[DW-1:0];
            tick();
        end
        rst_n    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 111, payload width (rd1, rd2, signimm, rs, rt, rd).
REQ-002 SHALL have parameter CTRL_W, default 8, control width (regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol[2:0]).
REQ-003 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; one clock, reset synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, upstream (decode) presents a valid instruction.
REQ-007 SHALL have port in_ready, output, 1, stage accepts input this cycle.
REQ-008 SHALL have port in_ctrl, input, CTRL_W, decode control bits.
REQ-009 SHALL have port in_data, input, DATA_W, decode payload.
REQ-010 SHALL have port flush, input, 1, kill all held instructions.
REQ-011 SHALL have port out_valid, output, 1, execute-side instruction valid.
REQ-012 SHALL have port out_ready, input, 1, execute stage consumes this cycle.
REQ-013 SHALL have ports out_ctrl (output, CTRL_W) and out_data (output, DATA_W), the held instruction.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, statistics.

Function
REQ-015 SHALL hold up to two entries: main register and skid register, each with ctrl, data, valid.
REQ-016 SHALL implement states EMPTY (none valid), FULL (main valid), SKID (main and skid valid).
REQ-017 SHALL drive in_ready = 1 in EMPTY and FULL, 0 in SKID, from registered state only (no combinational path from out_ready).
REQ-018 SHALL transition EMPTY -> FULL on in_valid, loading main.
REQ-019 SHALL, in FULL: in_valid & out_ready -> FULL, main <= input; in_valid & !out_ready -> SKID, skid <= input; !in_valid & out_ready -> EMPTY; otherwise hold.
REQ-020 SHALL, in SKID: out_ready -> FULL, main <= skid, skid cleared; otherwise hold; input ignored.
REQ-021 SHALL give latency of exactly one cycle from accepted input to out_valid when the stage was EMPTY or draining.
REQ-022 SHALL present entries in acceptance order; no drop, no duplication without flush.
REQ-023 SHALL, on flush=1, go to EMPTY next cycle with main and skid ctrl, data, valid = 0, discarding any same-cycle input even if in_valid & in_ready.
REQ-024 SHALL give flush priority over every handshake event; rst_n=0 has priority over flush.
REQ-025 SHALL drive out_ctrl and out_data to all zeros whenever out_valid = 0 (bubble = no-op).
REQ-026 SHALL increment stall_cnt each cycle with out_valid & !out_ready, saturating at 2^CNT_W-1.
REQ-027 SHALL increment flush_cnt each cycle with flush=1 and rst_n=1, saturating at 2^CNT_W-1.
REQ-028 SHALL clear counters only by reset; flush does not clear them.

Reset
REQ-029 SHALL, when rst_n=0 at a clock edge, set state EMPTY, all valid/ctrl/data = 0, both counters = 0.
REQ-030 SHALL, immediately after reset, show in_ready=1, out_valid=0, out_ctrl=0, out_data=0.
REQ-031 SHALL discard held entries on reset mid-operation with no output of them afterwards.

Structure
REQ-032 SHALL place state enum (EMPTY, FULL, SKID) and default CTRL_W/DATA_W/CNT_W constants in shared package pipe_pkg.
REQ-033 SHALL instantiate sub-module sat_counter (parametrised CNT_W, inc, synchronous active-low clear) twice for the statistics.

Verification
REQ-034 SHALL cover: reset, then in_valid=1, ctrl=0x1F, data=0x5 one cycle, out_ready=1 -> out_valid=1, out_ctrl=0x1F next cycle, EMPTY after consumption.
REQ-035 SHALL cover: out_ready=0, push A=0x11 then B=0x22 -> in_ready=0 after B; release out_ready -> A then B on consecutive cycles; stall_cnt counts stalled cycles.
REQ-036 SHALL cover: SKID state with in_valid=1, flush=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, flush_cnt=1, input never appears.
REQ-037 SHALL cover: continuous in_valid=1, out_ready=1 for 100 cycles, data 0..99 -> output 0..99 in order, one per cycle, stall_cnt=0.
REQ-038 SHALL cover: CNT_W=4, out_ready=0 with valid held 20 cycles -> stall_cnt saturates at 15.
REQ-039 SHALL cover: rst_n=0 asserted in SKID with flush=1 -> all outputs zero, counters zero, flush_cnt not incremented.
